// File: rtl/systolic_pkg.sv
// Shared defaults and helpers for the systolic matrix-multiply core.
// Build option: SYSTOLIC_SATURATE_EN selects saturating accumulation in systolic_mac.
package systolic_pkg;

  localparam int unsigned DefDim    = 8;
  localparam int unsigned DefBitsAb = 8;
  localparam int unsigned DefBitsC  = 16;

  // Accumulator clamp bounds for the default C width.
  localparam int SatMaxDef = (2 ** (DefBitsC - 1)) - 1;
  localparam int SatMinDef = -(2 ** (DefBitsC - 1));

  // Enabled steps needed for the last skewed operand pair to reach cell (DIM-1,DIM-1).
  function automatic int unsigned drain_steps(input int unsigned dim);
    return 3 * dim - 2;
  endfunction

endpackage

// File: rtl/systolic_mac.sv
// One signed multiply-accumulate cell: A/B pass-through registers plus a C accumulator.
// Build option: SYSTOLIC_SATURATE_EN clamps the accumulator instead of wrapping.
module systolic_mac
  import systolic_pkg::*;
#(
  parameter int unsigned BITS_AB = DefBitsAb,
  parameter int unsigned BITS_C  = DefBitsC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               ld,
  input  logic [BITS_C-1:0]  ld_data,
  input  logic [BITS_AB-1:0] a_in,
  input  logic [BITS_AB-1:0] b_in,
  output logic [BITS_AB-1:0] a_out,
  output logic [BITS_AB-1:0] b_out,
  output logic [BITS_C-1:0]  c_out
);

  localparam int unsigned PW = 2 * BITS_AB;
  localparam int unsigned EW = (BITS_C > PW) ? BITS_C : PW;

  logic [BITS_AB-1:0] a_q, b_q;
  logic [BITS_C-1:0]  c_q, c_d, acc;
  logic signed [PW-1:0] prod;
  logic signed [EW-1:0] prod_ext;
  logic [BITS_C-1:0]    prod_c;

  // Full-precision signed product, then sign-extend or truncate to the accumulator width.
  assign prod     = $signed(a_in) * $signed(b_in);
  assign prod_ext = EW'(prod);
  assign prod_c   = prod_ext[BITS_C-1:0];

`ifdef SYSTOLIC_SATURATE_EN
  logic [BITS_C:0] sum;

  // One extra bit exposes overflow; clamp toward the sign of the true result.
  always_comb begin
    sum = {c_q[BITS_C-1], c_q} + {prod_c[BITS_C-1], prod_c};
    if (sum[BITS_C] != sum[BITS_C-1]) begin
      acc = sum[BITS_C] ? {1'b1, {(BITS_C-1){1'b0}}} : {1'b0, {(BITS_C-1){1'b1}}};
    end else begin
      acc = sum[BITS_C-1:0];
    end
  end
`else
  // Two's-complement wraparound.
  assign acc = c_q + prod_c;
`endif

  // Load has priority over accumulate.
  always_comb begin
    c_d = c_q;
    if (ld) begin
      c_d = ld_data;
    end else if (en) begin
      c_d = acc;
    end
  end

  // Operand pipeline and accumulator state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
    end else begin
      if (en) begin
        a_q <= a_in;
        b_q <= b_in;
      end
      c_q <= c_d;
    end
  end

  assign a_out = a_q;
  assign b_out = b_q;
  assign c_out = c_q;

endmodule

// File: rtl/systolic_array.sv
// DIM x DIM systolic MAC grid with row-addressed C load/readout and a drain step counter.
// Build option: SYSTOLIC_SATURATE_EN (passed through to systolic_mac).
module systolic_array
  import systolic_pkg::*;
#(
  parameter int unsigned DIM     = DefDim,
  parameter int unsigned BITS_AB = DefBitsAb,
  parameter int unsigned BITS_C  = DefBitsC,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     WrEn,
  input  logic [$clog2(DIM)-1:0]   Crow,
  input  logic [DIM*BITS_AB-1:0]   A,
  input  logic [DIM*BITS_AB-1:0]   B,
  input  logic [DIM*BITS_C-1:0]    Cin,
  output logic [DIM*BITS_C-1:0]    Cout,
  output logic                     done
);

  localparam int unsigned RW = $clog2(DIM);
  localparam logic [CNT_W-1:0] Drain = CNT_W'(drain_steps(DIM));

  logic [BITS_AB-1:0] a_grid [DIM][DIM+1];
  logic [BITS_AB-1:0] b_grid [DIM+1][DIM];
  logic [BITS_C-1:0]  c_grid [DIM][DIM];
  logic [DIM-1:0]     row_ld;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q;

  for (genvar i = 0; i < DIM; i++) begin : g_edge
    logic unused_a_edge, unused_b_edge;
    assign a_grid[i][0] = A[i*BITS_AB +: BITS_AB];
    assign b_grid[0][i] = B[i*BITS_AB +: BITS_AB];
    // Out-of-range Crow matches no row, so such loads are dropped.
    assign row_ld[i]    = WrEn && (Crow == RW'(i));
    // Operands leaving the far edges are discarded.
    assign unused_a_edge = ^a_grid[i][DIM];
    assign unused_b_edge = ^b_grid[DIM][i];
  end

  for (genvar i = 0; i < DIM; i++) begin : g_row
    for (genvar j = 0; j < DIM; j++) begin : g_col
      systolic_mac #(
        .BITS_AB(BITS_AB),
        .BITS_C (BITS_C)
      ) u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .ld     (row_ld[i]),
        .ld_data(Cin[j*BITS_C +: BITS_C]),
        .a_in   (a_grid[i][j]),
        .b_in   (b_grid[i][j]),
        .a_out  (a_grid[i][j+1]),
        .b_out  (b_grid[i+1][j]),
        .c_out  (c_grid[i][j])
      );
    end
  end

  // Row readout mux; reads 0 when Crow selects no row.
  always_comb begin
    Cout = '0;
    for (int r = 0; r < DIM; r++) begin
      if (Crow == RW'(r)) begin
        for (int j = 0; j < DIM; j++) begin
          Cout[j*BITS_C +: BITS_C] = c_grid[r][j];
        end
      end
    end
  end

  // Step counter: a load restarts it and swallows a coincident en step; saturates at Drain.
  always_comb begin
    cnt_d = cnt_q;
    if (WrEn) begin
      cnt_d = '0;
    end else if (en && (cnt_q != Drain)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter and registered done flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= (cnt_d == Drain);
    end
  end

  assign done = done_q;

endmodule

// File: tb/tb_systolic_array.sv
// Self-checking bench for systolic_array against an operand-history model of the grid.
// Build option: SYSTOLIC_SATURATE_EN selects the saturating expectations.
module tb_systolic_array;

  localparam int DIM   = 8;
  localparam int BAB   = 8;
  localparam int BC    = 16;
  localparam int DRAIN = 3 * DIM - 2;
  localparam int MAXS  = 8192;

  logic                clk = 1'b0;
  logic                rst_n, en, wr_en;
  logic [2:0]          crow;
  logic [DIM*BAB-1:0]  a_vec, b_vec;
  logic [DIM*BC-1:0]   cin, cout;
  logic                done;

  always #5 clk = ~clk;

  systolic_array dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .WrEn (wr_en),
    .Crow (crow),
    .A    (a_vec),
    .B    (b_vec),
    .Cin  (cin),
    .Cout (cout),
    .done (done)
  );

  int checks = 0;
  int errors = 0;

  // Model: C per cell, plus the history of every edge operand indexed by enabled step.
  int c_m [DIM][DIM];
  int a_hist [MAXS][DIM];
  int b_hist [MAXS][DIM];
  int s_cnt = 0;
  int base  = 0;
  int cnt_m = 0;
  bit done_m = 1'b0;
  bit chk_on = 1'b0;

  function automatic int sx8(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  function automatic int sx16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic int fit_c(input int v);
    logic signed [15:0] t;
`ifdef SYSTOLIC_SATURATE_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
`else
    t = v[15:0];
    return int'(t);
`endif
  endfunction

  // Operand seen at row i / column j on enabled step t (zero if it predates the last reset).
  function automatic int a_at(input int i, input int t);
    if (t < base) return 0;
    return a_hist[t][i];
  endfunction

  function automatic int b_at(input int j, input int t);
    if (t < base) return 0;
    return b_hist[t][j];
  endfunction

  function automatic logic [DIM*BC-1:0] exp_row(input int r);
    logic [DIM*BC-1:0] v;
    int t;
    v = '0;
    for (int j = 0; j < DIM; j++) begin
      t = c_m[r][j];
      v[j*BC +: BC] = t[BC-1:0];
    end
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) c_m[i][j] = 0;
    base   = s_cnt;
    cnt_m  = 0;
    done_m = 1'b0;
  endtask

  task automatic model_step();
    if (s_cnt >= MAXS) begin
      $display("FAIL model_capacity steps=%0d limit=%0d", s_cnt, MAXS);
      $fatal(1);
    end
    if (en) begin
      for (int k = 0; k < DIM; k++) begin
        a_hist[s_cnt][k] = sx8(a_vec[k*BAB +: BAB]);
        b_hist[s_cnt][k] = sx8(b_vec[k*BAB +: BAB]);
      end
    end
    for (int i = 0; i < DIM; i++) begin
      for (int j = 0; j < DIM; j++) begin
        if (wr_en && (int'(crow) == i)) c_m[i][j] = sx16(cin[j*BC +: BC]);
        else if (en) c_m[i][j] = fit_c(c_m[i][j] + a_at(i, s_cnt - j) * b_at(j, s_cnt - i));
      end
    end
    if (wr_en) cnt_m = 0;
    else if (en && cnt_m < DRAIN) cnt_m++;
    done_m = (cnt_m == DRAIN);
    if (en) s_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #2;
  endtask

  // Continuous comparison of the selected row and done against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      checks++;
      if (cout !== exp_row(int'(crow))) begin
        errors++;
        $display("FAIL row_cmp crow=%0d got %h want %h", crow, cout, exp_row(int'(crow)));
      end
      checks++;
      if (done !== done_m) begin
        errors++;
        $display("FAIL done_cmp got %b want %b", done, done_m);
      end
    end
  end

  task automatic lit_row(input int r, input logic [DIM*BC-1:0] expv, input string nm);
    crow = r[2:0];
    #1;
    checks++;
    if (cout !== expv) begin
      errors++;
      $display("FAIL %s row=%0d got %h want %h", nm, r, cout, expv);
    end
  endtask

  task automatic lit_done(input logic expv, input string nm);
    checks++;
    if (done !== expv) begin
      errors++;
      $display("FAIL %s done got %b want %b", nm, done, expv);
    end
  endtask

  task automatic lit_c00(input logic [15:0] expv, input string nm);
    crow = 3'd0;
    #1;
    checks++;
    if (cout[15:0] !== expv) begin
      errors++;
      $display("FAIL %s c00 got %h want %h", nm, cout[15:0], expv);
    end
  endtask

  task automatic clear_c();
    en    = 1'b0;
    wr_en = 1'b1;
    cin   = '0;
    for (int r = 0; r < DIM; r++) begin
      crow = r[2:0];
      tick();
    end
    wr_en = 1'b0;
  endtask

  // Skewed identity x (B[i][j]=i+j) feed; optionally stalls hold_len cycles before step hold_at.
  task automatic run_identity(input int hold_at, input int hold_len);
    int m;
    wr_en = 1'b0;
    for (int s = 0; s < DRAIN; s++) begin
      if (s == hold_at) begin
        en = 1'b0;
        repeat (hold_len) tick();
        lit_done(1'b0, "hold_done_low");
      end
      for (int k = 0; k < DIM; k++) begin
        m = s - k;
        a_vec[k*BAB +: BAB] = (m == k) ? 8'd1 : 8'd0;
        b_vec[k*BAB +: BAB] = (m >= 0 && m < DIM) ? 8'(m + k) : 8'd0;
      end
      en = 1'b1;
      tick();
      if (s == DRAIN - 2) lit_done(1'b0, "done_before_drain");
    end
    lit_done(1'b1, "done_at_drain");
    en    = 1'b0;
    a_vec = '0;
    b_vec = '0;
  endtask

  task automatic check_identity(input string nm);
    logic [DIM*BC-1:0] v;
    for (int r = 0; r < DIM; r++) begin
      for (int j = 0; j < DIM; j++) v[j*BC +: BC] = 16'(r + j);
      lit_row(r, v, nm);
      tick();
    end
  endtask

  logic [DIM*BC-1:0] saved;

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    wr_en = 1'b0;
    crow  = '0;
    a_vec = '0;
    b_vec = '0;
    cin   = '0;
    model_reset();
    chk_on = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    for (int r = 0; r < DIM; r++) begin
      lit_row(r, '0, "reset_row");
      lit_done(1'b0, "reset_done");
      tick();
    end

    // Row load and readback
    wr_en = 1'b1;
    crow  = 3'd3;
    cin   = {DIM{16'h0005}};
    tick();
    wr_en = 1'b0;
    for (int r = 0; r < DIM; r++) begin
      lit_row(r, (r == 3) ? {DIM{16'h0005}} : '0, "load_row");
      lit_done(1'b0, "load_done");
      tick();
    end

    // Identity multiply, uninterrupted then with a 5-cycle stall
    clear_c();
    run_identity(-1, 0);
    checks++;
    if (c_m[3][4] != 7 || c_m[7][7] != 14) begin
      errors++;
      $display("FAIL model_pin c34=%0d c77=%0d want 7 14", c_m[3][4], c_m[7][7]);
    end
    check_identity("identity");
    clear_c();
    run_identity(10, 5);
    check_identity("identity_hold");

    // Signed overflow at cell (0,0)
    wr_en = 1'b1;
    crow  = 3'd0;
    cin   = '0;
    cin[15:0] = 16'h7FFF;
    tick();
    wr_en = 1'b0;
    a_vec = '0;
    b_vec = '0;
    a_vec[7:0] = 8'd1;
    b_vec[7:0] = 8'd1;
    en = 1'b1;
    tick();
    en = 1'b0;
`ifdef SYSTOLIC_SATURATE_EN
    lit_c00(16'h7FFF, "ovf_pos");
`else
    lit_c00(16'h8000, "ovf_pos");
`endif
    wr_en = 1'b1;
    cin[15:0] = 16'h8000;
    tick();
    wr_en = 1'b0;
    a_vec[7:0] = 8'h80;
    b_vec[7:0] = 8'h7F;
    en = 1'b1;
    tick();
    en = 1'b0;
`ifdef SYSTOLIC_SATURATE_EN
    lit_c00(16'h8000, "ovf_neg");
`else
    lit_c00(16'h4080, "ovf_neg");
`endif

    // Load/accumulate collision, counter restart
    a_vec = {$urandom, $urandom};
    b_vec = {$urandom, $urandom};
    cin   = {$urandom, $urandom, $urandom, $urandom};
    saved = cin;
    crow  = 3'd2;
    en    = 1'b1;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    en    = 1'b0;
    lit_row(2, saved, "collide_load");
    lit_done(1'b0, "collide_done");
    en = 1'b1;
    for (int s = 0; s < DRAIN; s++) begin
      a_vec = {$urandom, $urandom};
      b_vec = {$urandom, $urandom};
      crow  = 3'($urandom);
      tick();
      if (s == DRAIN - 2) lit_done(1'b0, "restart_before");
    end
    lit_done(1'b1, "restart_at_drain");

    // Asynchronous reset mid-run
    repeat (3) tick();
    en    = 1'b0;
    rst_n = 1'b0;
    model_reset();
    lit_row(int'(crow), '0, "async_rst_row");
    lit_done(1'b0, "async_rst_done");
    for (int r = 0; r < DIM; r++) begin
      tick();
      lit_row(r, '0, "rst_sweep");
    end
    rst_n = 1'b1;
    tick();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        en    = 1'b0;
        wr_en = 1'b0;
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
      end
      en    = ($urandom_range(0, 3) != 0);
      wr_en = ($urandom_range(0, 19) == 0);
      crow  = 3'($urandom);
      a_vec = {$urandom, $urandom};
      b_vec = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) a_vec = {DIM{8'h80}};
      if ($urandom_range(0, 3) == 0) b_vec = {DIM{8'h7F}};
      cin = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    en    = 1'b0;
    wr_en = 1'b0;
    repeat (2) tick();
    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
